// File: rtl/lfsr_run_controller_if.sv
// Command channel for the LED LFSR run controller: op/seed/taps with valid/ready handshake.
interface lfsr_run_controller_if #(
   parameter int unsigned WIDTH = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [WIDTH-1:0] tap_mask;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_data,
      output tap_mask,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_data,
      input  tap_mask,
      output cmd_ready
   );
endinterface

// File: rtl/lfsr_run_controller.sv
// Sequencer for the LED Fibonacci LFSR: paced RUN, single STEP, seed/tap LOAD,
// period measurement and all-zero lockup protection.
module lfsr_run_controller #(
   parameter int unsigned      WIDTH        = 4,
   parameter int unsigned      DIV_MAX      = 6000000,
   parameter logic [WIDTH-1:0] DEFAULT_TAPS = 4'b1100
) (
   input  logic                  clk,
   input  logic                  rst,
   lfsr_run_controller_if.slave  cmd,
   output logic [WIDTH-1:0]      lfsr_q,
   output logic [WIDTH-1:0]      led,
   output logic                  running,
   output logic                  period_done,
   output logic [15:0]           period_len,
   output logic                  zero_fault
);

   localparam int unsigned CntW = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
   localparam logic [CntW-1:0] TickLast = CntW'(DIV_MAX - 1);

   localparam logic [1:0] OpLoad  = 2'b00;
   localparam logic [1:0] OpRun   = 2'b01;
   localparam logic [1:0] OpPause = 2'b10;
   localparam logic [1:0] OpStep  = 2'b11;

   typedef enum logic [1:0] {StIdle, StRun, StPause, StStep} state_t;

   state_t           state, step_ret;
   logic [WIDTH-1:0] seed, taps;
   logic [CntW-1:0]  tick_cnt;
   logic [15:0]      step_cnt;
   logic             ready_q;

   logic             accept, tick, advance;
   logic [WIDTH-1:0] next_val;

   assign cmd.cmd_ready = ready_q;

   always_comb begin
      accept   = cmd.cmd_valid && ready_q;
      tick     = (state == StRun) && (tick_cnt == TickLast);
      // An accepted command wins over a coincident tick.
      advance  = (tick && !accept) || (state == StStep);
      next_val = {lfsr_q[WIDTH-2:0], ^(lfsr_q & taps)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StIdle;
         step_ret    <= StIdle;
         lfsr_q      <= '1;
         seed        <= '1;
         taps        <= DEFAULT_TAPS;
         led         <= '1;
         tick_cnt    <= '0;
         step_cnt    <= '0;
         running     <= 1'b0;
         period_done <= 1'b0;
         period_len  <= '0;
         zero_fault  <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         led         <= lfsr_q;
         period_done <= 1'b0;
         if (state == StRun) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

         if (accept) begin
            unique case (cmd.cmd_op)
               OpLoad: begin
                  if (cmd.cmd_data == '0) begin
                     zero_fault <= 1'b1;
                  end else begin
                     lfsr_q     <= cmd.cmd_data;
                     seed       <= cmd.cmd_data;
                     taps       <= cmd.tap_mask;
                     step_cnt   <= '0;
                     zero_fault <= 1'b0;
                     state      <= StIdle;
                     running    <= 1'b0;
                  end
               end
               OpRun: begin
                  if (state == StIdle || state == StPause) begin
                     state    <= StRun;
                     running  <= 1'b1;
                     tick_cnt <= '0;
                  end
               end
               OpPause: begin
                  if (state == StRun) begin
                     state   <= StPause;
                     running <= 1'b0;
                  end
               end
               OpStep: begin
                  if (state == StIdle || state == StPause) begin
                     step_ret <= state;
                     state    <= StStep;
                     ready_q  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end else if (advance) begin
            if (next_val == '0) begin
               zero_fault <= 1'b1;
               state      <= StIdle;
               running    <= 1'b0;
               ready_q    <= 1'b1;
            end else begin
               lfsr_q <= next_val;
               if (next_val == seed) begin
                  period_done <= 1'b1;
                  period_len  <= (step_cnt == 16'hFFFF) ? 16'hFFFF : step_cnt + 16'd1;
                  step_cnt    <= '0;
               end else if (step_cnt != 16'hFFFF) begin
                  step_cnt <= step_cnt + 16'd1;
               end
               if (state == StStep) begin
                  state   <= step_ret;
                  ready_q <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_run_controller.sv
// Directed bench for lfsr_run_controller with a short tick divider (DIV_MAX = 4).
module tb_lfsr_run_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  lfsr_q, led;
   logic        running, period_done, zero_fault;
   logic [15:0] period_len;
   int          total = 0;
   int          bad = 0;

   lfsr_run_controller_if #(.WIDTH(4)) cmd_if ();

   lfsr_run_controller #(
      .WIDTH       (4),
      .DIV_MAX     (4),
      .DEFAULT_TAPS(4'b1100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd        (cmd_if),
      .lfsr_q     (lfsr_q),
      .led        (led),
      .running    (running),
      .period_done(period_done),
      .period_len (period_len),
      .zero_fault (zero_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [3:0] taps);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_data  = data;
      cmd_if.tap_mask  = taps;
      @(posedge clk);
      #1;
      cmd_if.cmd_valid = 1'b0;
   endtask

   initial begin
      logic [3:0] seq [15];
      logic [3:0] steps [3];
      seq = '{4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
              4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111};
      steps = '{4'b1110, 4'b1100, 4'b1000};
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 2'b00;
      cmd_if.cmd_data  = 4'h0;
      cmd_if.tap_mask  = 4'h0;

      // Reset values
      #12;
      check("rst_lfsr", 16'(lfsr_q), 16'hF);
      check("rst_led", 16'(led), 16'hF);
      check("rst_running", 16'(running), 16'h0);
      check("rst_pdone", 16'(period_done), 16'h0);
      check("rst_plen", period_len, 16'h0);
      check("rst_zfault", 16'(zero_fault), 16'h0);
      check("rst_ready", 16'(cmd_if.cmd_ready), 16'h1);
      rst = 1'b0;
      step(1);

      // Full period in RUN, one advance every 4 clocks
      send(2'b01, 4'h0, 4'h0);
      check("run_running", 16'(running), 16'h1);
      step(4);
      for (int i = 0; i < 15; i++) begin
         check($sformatf("run_lfsr%0d", i), 16'(lfsr_q), 16'(seq[i]));
         check($sformatf("run_pdone%0d", i), 16'(period_done), (i == 14) ? 16'h1 : 16'h0);
         step(1);
         check($sformatf("run_led%0d", i), 16'(led), 16'(seq[i]));
         if (i < 14) step(3);
      end
      check("run_plen", period_len, 16'd15);
      check("run_pdone_drop", 16'(period_done), 16'h0);

      // PAUSE, then rejected zero LOAD, then valid LOAD
      send(2'b10, 4'h0, 4'h0);
      check("pause_running", 16'(running), 16'h0);
      step(8);
      check("pause_hold", 16'(lfsr_q), 16'hF);
      send(2'b00, 4'h0, 4'hC);
      check("load0_zfault", 16'(zero_fault), 16'h1);
      check("load0_lfsr", 16'(lfsr_q), 16'hF);
      check("load0_running", 16'(running), 16'h0);
      send(2'b00, 4'h1, 4'hC);
      check("load1_zfault", 16'(zero_fault), 16'h0);
      check("load1_lfsr", 16'(lfsr_q), 16'h1);
      check("load1_running", 16'(running), 16'h0);

      // Three STEPs from IDLE
      send(2'b00, 4'hF, 4'hC);
      for (int i = 0; i < 3; i++) begin
         send(2'b11, 4'h0, 4'h0);
         check($sformatf("step_ready_lo%0d", i), 16'(cmd_if.cmd_ready), 16'h0);
         check($sformatf("step_running%0d", i), 16'(running), 16'h0);
         step(1);
         check($sformatf("step_lfsr%0d", i), 16'(lfsr_q), 16'(steps[i]));
         check($sformatf("step_ready_hi%0d", i), 16'(cmd_if.cmd_ready), 16'h1);
      end

      // PAUSE exactly on the tick edge suppresses the advance
      send(2'b01, 4'h0, 4'h0);
      step(3);
      send(2'b10, 4'h0, 4'h0);
      check("tickpause_lfsr", 16'(lfsr_q), 16'h8);
      check("tickpause_running", 16'(running), 16'h0);
      step(10);
      check("tickpause_hold", 16'(lfsr_q), 16'h8);
      send(2'b01, 4'h0, 4'h0);
      step(3);
      check("resume_early", 16'(lfsr_q), 16'h8);
      step(1);
      check("resume_adv", 16'(lfsr_q), 16'h1);

      // Lockup guard with empty tap mask
      send(2'b10, 4'h0, 4'h0);
      send(2'b00, 4'h1, 4'h0);
      send(2'b01, 4'h0, 4'h0);
      step(4);
      check("lock_a1", 16'(lfsr_q), 16'h2);
      step(4);
      check("lock_a2", 16'(lfsr_q), 16'h4);
      step(4);
      check("lock_a3", 16'(lfsr_q), 16'h8);
      check("lock_zf_pre", 16'(zero_fault), 16'h0);
      step(4);
      check("lock_lfsr", 16'(lfsr_q), 16'h8);
      check("lock_zfault", 16'(zero_fault), 16'h1);
      check("lock_running", 16'(running), 16'h0);

      // Asynchronous reset mid-RUN
      send(2'b00, 4'hF, 4'hC);
      send(2'b01, 4'h0, 4'h0);
      step(28);
      check("pre_rst_lfsr", 16'(lfsr_q), 16'h9);
      step(1);
      check("pre_rst_led", 16'(led), 16'h9);
      rst = 1'b1;
      #1;
      check("mid_rst_lfsr", 16'(lfsr_q), 16'hF);
      check("mid_rst_led", 16'(led), 16'hF);
      check("mid_rst_running", 16'(running), 16'h0);
      check("mid_rst_plen", period_len, 16'h0);
      check("mid_rst_ready", 16'(cmd_if.cmd_ready), 16'h1);
      check("mid_rst_pdone", 16'(period_done), 16'h0);
      rst = 1'b0;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
